// File: rtl/dmem_stage_mc.sv
// Multi-cycle data-memory stage for the MEM pipeline stage: request/stall/done
// handshake, configurable latency, store-data forwarding and request error detection.
module dmem_stage_mc #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int LAT         = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] memDataMemWb,
    input  logic              forwardC,
    input  logic              halt,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    stateT                 state;
    logic [CNT_W-1:0]      counter;
    logic                  capRd;
    logic                  capWr;
    logic                  capErr;
    logic [DEPTH_LOG2-1:0] capIdx;
    logic [DATA_W-1:0]     capData;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  req;
    logic                  reqErr;
    logic [DEPTH_LOG2-1:0] reqIdx;
    logic [DATA_W-1:0]     reqData;
    logic                  unusedAddrBits;

    // Address bits above the word index are deliberately ignored (index wrap-around).
    assign unusedAddrBits = ^memAddr;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        req     = (MemRead | MemWrite) & ~halt;
        reqErr  = (MemRead & MemWrite) | ((ALIGN_CHECK != 0) & memAddr[0]);
        reqIdx  = memAddr[DEPTH_LOG2:1];
        reqData = forwardC ? memDataMemWb : writeData;
        stall   = ((state == IDLE) & req) | (state == BUSY);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            readData <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            capRd    <= 1'b0;
            capWr    <= 1'b0;
            capErr   <= 1'b0;
            capIdx   <= '0;
            capData  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        capRd   <= MemRead;
                        capWr   <= MemWrite;
                        capErr  <= reqErr;
                        capIdx  <= reqIdx;
                        capData <= reqData;
                        counter <= CNT_W'(LAT - 1);
                        if (LAT > 1) begin
                            state <= BUSY;
                        end else begin
                            // Single-cycle latency: complete straight from the live inputs.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= reqErr;
                            if (MemRead && !reqErr) begin
                                readData <= mem[reqIdx];
                            end
                        end
                    end
                end
                BUSY: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= capErr;
                        if (capRd && !capErr) begin
                            readData <= mem[capIdx];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the array is built from flops rather than a RAM macro because reset must clear every word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == DONE) && capWr && !capErr) begin
            mem[capIdx] <= capData;
        end
    end

endmodule

// File: tb/tb_dmem_stage_mc.sv
// Self-checking bench for dmem_stage_mc: a scoreboard of expected completions for the
// LAT=2 instance, plus latency checks on LAT=1 and LAT=4 instances sharing the stimulus.
module tb_dmem_stage_mc;

    localparam int LAT = 2;

    typedef struct {
        logic        isErr;
        logic [15:0] data;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] memAddr;
    logic [15:0] writeData;
    logic [15:0] memDataMemWb;
    logic        forwardC;
    logic        halt;

    logic [15:0] readData, readData1, readData4;
    logic        stall, stall1, stall4;
    logic        done, done1, done4;
    logic        err, err1, err4;

    int          nCompared   = 0;
    int          nMismatched = 0;
    int          cyc         = 0;

    expT         sbQ[$];
    expT         monExp;
    logic [15:0] model [1024];
    logic [15:0] modelRd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_stage_mc #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .memAddr(memAddr),
        .writeData(writeData), .memDataMemWb(memDataMemWb), .forwardC(forwardC), .halt(halt),
        .readData(readData), .stall(stall), .done(done), .err(err)
    );

    dmem_stage_mc #(.LAT(1)) dutL1 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .memAddr(memAddr),
        .writeData(writeData), .memDataMemWb(memDataMemWb), .forwardC(forwardC), .halt(halt),
        .readData(readData1), .stall(stall1), .done(done1), .err(err1)
    );

    dmem_stage_mc #(.LAT(4)) dutL4 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .memAddr(memAddr),
        .writeData(writeData), .memDataMemWb(memDataMemWb), .forwardC(forwardC), .halt(halt),
        .readData(readData4), .stall(stall4), .done(done4), .err(err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 1024; i++) model[i] = 16'h0000;
        modelRd = 16'h0000;
    endfunction

    // Reference behaviour of one accepted request; result queued for the done pulse.
    function automatic void pushExpected(input logic rd, input logic wr, input logic [15:0] addr,
                                         input logic [15:0] wd, input logic fwd,
                                         input logic [15:0] fwdd);
        logic       e;
        logic [9:0] idx;
        expT        x;
        e   = (rd & wr) | addr[0];
        idx = addr[10:1];
        if (!e && rd) modelRd = model[idx];
        if (!e && wr) model[idx] = fwd ? fwdd : wd;
        x.isErr = e;
        x.data  = modelRd;
        sbQ.push_back(x);
    endfunction

    // Scoreboard: every done pulse of the LAT=2 instance must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbQ.size() == 0) begin
                check("unexpectedDone", 32'(done), 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                check("sbErr", 32'(err), 32'(monExp.isErr));
                check("sbReadData", 32'(readData), 32'(monExp.data));
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        memAddr      = 16'h0000;
        writeData    = 16'h0000;
        memDataMemWb = 16'h0000;
        forwardC     = 1'b0;
        halt         = 1'b0;
    endtask

    // One request on the LAT=2 instance; inputs are held through the done cycle.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic fwd, input logic [15:0] fwdd,
                          input int haltAt, output int acceptCyc);
        @(posedge clk); #1;
        MemRead      = rd;
        MemWrite     = wr;
        memAddr      = addr;
        writeData    = wd;
        forwardC     = fwd;
        memDataMemWb = fwdd;
        halt         = 1'b0;
        acceptCyc    = cyc;
        pushExpected(rd, wr, addr, wd, fwd, fwdd);
        for (int c = 0; c <= LAT; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == haltAt) halt = 1'b1;
            end
            @(negedge clk);
            check("stallTiming", 32'(stall), 32'(c < LAT));
            check("doneTiming", 32'(done), 32'(c == LAT));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int wAcc;
        int rAcc;
        int dummy;

        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; memAddr = 16'h0; writeData = 16'h0;
        memDataMemWb = 16'h0; forwardC = 1'b0; halt = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstStall", 32'(stall), 32'd0);
        check("rstDone", 32'(done), 32'd0);
        check("rstErr", 32'(err), 32'd0);
        check("rstReadData", 32'(readData), 32'd0);

        access(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 16'h0, -1, dummy);

        // Back-to-back write then read: six cycles from first accept to read done.
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0, -1, wAcc);
        access(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, -1, rAcc);
        check("b2bAccept", 32'(rAcc - wAcc), 32'd3);
        check("b2bSpan", 32'(cyc - wAcc), 32'd5);
        idle();

        access(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h2222, -1, dummy);
        access(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, -1, dummy);

        // Error requests must leave the stored word untouched.
        access(1'b0, 1'b1, 16'h0030, 16'h1234, 1'b0, 16'h0, -1, dummy);
        access(1'b1, 1'b1, 16'h0030, 16'hDEAD, 1'b0, 16'h0, -1, dummy);
        access(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 16'h0, -1, dummy);
        access(1'b0, 1'b1, 16'h0031, 16'h9999, 1'b0, 16'h0, -1, dummy);
        access(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 16'h0, -1, dummy);
        idle();

        // Halt in IDLE blocks acceptance.
        @(posedge clk); #1;
        MemRead = 1'b1; memAddr = 16'h0040; halt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("haltStall", 32'(stall), 32'd0);
            check("haltDone", 32'(done), 32'd0);
        end
        idle();

        // Halt rising mid-flight does not stop completion, but blocks the next accept.
        access(1'b0, 1'b1, 16'h0040, 16'h00AA, 1'b0, 16'h0, 1, dummy);
        @(posedge clk); #1;
        @(negedge clk);
        check("haltAfterStall", 32'(stall), 32'd0);
        check("haltAfterDone", 32'(done), 32'd0);
        idle();
        access(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, -1, dummy);
        idle();

        // Reset in cycle 1 of a write aborts it without a done pulse.
        @(posedge clk); #1;
        MemWrite = 1'b1; memAddr = 16'h0050; writeData = 16'h5555;
        @(negedge clk);
        check("abortStall0", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        MemWrite = 1'b0; memAddr = 16'h0; writeData = 16'h0;
        modelReset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abortDone", 32'(done), 32'd0);
            check("abortIdle", 32'(stall), 32'd0);
        end
        check("abortReadData", 32'(readData), 32'd0);
        access(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0, -1, dummy);
        idle();

        // Fresh reset, then one read seen by all three latencies.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        @(posedge clk); #1;
        MemRead = 1'b1; memAddr = 16'h0050;
        pushExpected(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 1) begin
                    MemRead = 1'b0; memAddr = 16'h0;
                end
            end
            @(negedge clk);
            check("lat1Stall", 32'(stall1), 32'(c == 0));
            check("lat1Done", 32'(done1), 32'(c == 1));
            check("lat4Stall", 32'(stall4), 32'(c < 4));
            check("lat4Done", 32'(done4), 32'(c == 4));
            check("lat2Done", 32'(done), 32'(c == 2));
            if (c == 1) check("lat1ReadData", 32'(readData1), 32'd0);
            if (c == 4) check("lat4ReadData", 32'(readData4), 32'd0);
        end

        check("sbPending", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
